// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg : shared FSM, stuffing and line-state definitions for the USB TX path
// Revision: 1.0
// ============================================================================
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [2:0] EOP_SE0_BITS = 3'd2;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage
`default_nettype wire

// File: rtl/usb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// usb_bit_stuffer : run-of-ones tracker with stuff insertion and NRZI level
// Revision: 1.0
// ============================================================================
module usb_bit_stuffer (
  input  logic clk,
  input  logic n_rst,
  input  logic strobe,
  input  logic clear,
  input  logic bit_in,
  output logic stall,
  output logic level_next
);
  import usb_pkg::*;

  logic [2:0] ones_q, ones_d;
  logic       level_q, level_d;
  logic       stuffed_bit;

  // While stalled the caller's bit is ignored and a forced 0 goes out instead.
  assign stall       = (ones_q == STUFF_LIMIT);
  assign stuffed_bit = bit_in & ~stall;
  assign level_next  = stuffed_bit ? level_q : ~level_q;

  always_comb begin
    ones_d  = ones_q;
    level_d = level_q;
    if (strobe) begin
      level_d = level_next;
      ones_d  = stuffed_bit ? ones_q + 3'd1 : 3'd0;
    end else if (clear) begin
      level_d = 1'b1;
      ones_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q  <= 3'd0;
      level_q <= 1'b1;
    end else begin
      ones_q  <= ones_d;
      level_q <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// usb_tx_encoder : full-speed USB TX line encoder (SYNC, NRZI + stuffing, EOP)
// Revision: 1.0
// ============================================================================
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_err
);
  import usb_pkg::*;

  localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       shift_cnt_q, shift_cnt_d;
  logic             shift_last_q, shift_last_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             hold_last_q, hold_last_d;
  logic             last_acc_q, last_acc_d;
  logic [1:0]       line_q, line_d, line_set;
  logic             oe_q, oe_d;
  logic             err_q, err_d;

  logic accept, bit_end, fetch, strobe, data_bit, stall, level_next, stuff_clear;

  assign accept      = tx_valid & tx_ready;
  assign bit_end     = (bit_cnt_q == BIT_LAST);
  assign stuff_clear = (state_q != SYNC) && (state_q != DATA);

  usb_bit_stuffer u_stuffer (
    .clk        (clk),
    .n_rst      (n_rst),
    .strobe     (strobe),
    .clear      (stuff_clear),
    .bit_in     (data_bit),
    .stall      (stall),
    .level_next (level_next)
  );

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    shift_cnt_d  = shift_cnt_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    last_acc_d   = last_acc_q;
    line_set     = line_q;
    oe_d         = oe_q;
    err_d        = 1'b0;
    fetch        = 1'b0;
    strobe       = 1'b0;
    data_bit     = 1'b0;
    bit_cnt_d    = (state_q == IDLE || bit_end) ? '0 : bit_cnt_q + 1'b1;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      hold_last_d = tx_last;
      if (tx_last) last_acc_d = 1'b1;
    end

    case (state_q)
      IDLE: if (accept) begin
        state_d      = SYNC;
        bit_idx_d    = 3'd0;
        shift_cnt_d  = 3'd0;
        shift_last_d = 1'b0;
        oe_d         = 1'b1;
        strobe       = 1'b1;
        data_bit     = SYNC_BYTE[0];
      end
      SYNC: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
          state_d = DATA;
          fetch   = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          strobe    = 1'b1;
          data_bit  = SYNC_BYTE[bit_idx_q + 3'd1];
        end
      end
      DATA: if (bit_end) begin
        if (stall) strobe = 1'b1;
        else       fetch  = 1'b1;
      end
      EOP_SE0: if (bit_end) begin
        if (bit_idx_q == EOP_SE0_BITS - 3'd1) begin
          state_d  = EOP_J;
          line_set = LINE_J;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      EOP_J: if (bit_end) begin
        state_d    = IDLE;
        oe_d       = 1'b0;
        last_acc_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving exactly on an empty-boundary bypasses hold so it is never stranded.
    if (fetch) begin
      if (shift_cnt_q != 3'd0) begin
        strobe      = 1'b1;
        data_bit    = shift_q[0];
        shift_d     = {1'b0, shift_q[7:1]};
        shift_cnt_d = shift_cnt_q - 3'd1;
      end else if (hold_full_q || accept) begin
        strobe       = 1'b1;
        data_bit     = hold_full_q ? hold_q[0] : tx_data[0];
        shift_d      = {1'b0, (hold_full_q ? hold_q[7:1] : tx_data[7:1])};
        shift_cnt_d  = 3'd7;
        shift_last_d = hold_full_q ? hold_last_q : tx_last;
        hold_full_d  = 1'b0;
      end else begin
        state_d   = EOP_SE0;
        bit_idx_d = 3'd0;
        line_set  = LINE_SE0;
        err_d     = ~shift_last_q;
      end
    end
  end

  assign line_d = strobe ? (level_next ? LINE_J : LINE_K) : line_set;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      shift_cnt_q  <= 3'd0;
      shift_last_q <= 1'b0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      line_q       <= LINE_J;
      oe_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      shift_cnt_q  <= shift_cnt_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      last_acc_q   <= last_acc_d;
      line_q       <= line_d;
      oe_q         <= oe_d;
      err_q        <= err_d;
    end
  end

  assign dp       = line_q[1];
  assign dm       = line_q[0];
  assign tx_oe    = oe_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_err   = err_q;
  assign tx_ready = ~hold_full_q & ~last_acc_q & (state_q != EOP_SE0) & (state_q != EOP_J);

endmodule
`default_nettype wire

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
- Full-speed USB 1.1 transmit line encoder; the transmit-side counterpart of the RX path's EOP detection and NRZI decode.
- Accepts packet bytes over a valid/ready stream and emits SYNC, then NRZI-encoded data with bit stuffing, then EOP (SE0 SE0 J).
- Drives dp/dm and an output enable toward the transceiver pads.

Parameters:
CLKS_PER_BIT, 4, clk cycles per USB bit time (≥2); bit-time counter width = $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
tx_valid  input  1  tx_data/tx_last valid
tx_data  input  8  packet byte, sent LSB first
tx_last  input  1  byte is the final byte of the packet
tx_ready  output  1  byte accepted when tx_valid && tx_ready
dp  output  1  D+ line level
dm  output  1  D- line level
tx_oe  output  1  high while driving a packet (SYNC through final EOP J)
tx_busy  output  1  high from first accept until tx_oe falls
tx_err  output  1  one-cycle pulse on underrun abort

Behaviour:
- Reset: dp=1, dm=0 (J), tx_oe=0, tx_busy=0, tx_err=0, tx_ready=1. FSM=IDLE. Counters, shift register and hold register are cleared. Reset mid-packet aborts immediately with no EOP.
- Line symbols: J = dp1/dm0; K = dp0/dm1; SE0 = dp0/dm0. dp/dm/tx_oe are registered.
- Buffering: one shift register plus one holding register. tx_ready = !hold_full, except it is forced 0 in EOP_SE0 and EOP_J, and 0 after a tx_last byte is accepted until IDLE.
- FSM IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
- IDLE: on handshake at cycle T, the byte goes to hold, tx_busy=1, FSM -> SYNC. At T+1, tx_oe=1 and line = K.
- SYNC: 8 bit times of K J K J K J K K (data 0x80, LSB first, NRZI-encoded). Each bit time lasts exactly CLKS_PER_BIT cycles; the bit counter restarts at every bit boundary.
- DATA: at each bit boundary the next bit is shifted out of the shift register. The shift register reloads from hold when it empties.
- NRZI: bit 0 toggles J/K; bit 1 holds the current level.
- Stuffing: ones_cnt counts consecutive 1 bits and includes the final SYNC bit (ones_cnt=1 entering DATA).
  - When ones_cnt reaches 6, the next bit time is a stuffed 0 (toggle) and ones_cnt clears. Data bits are not consumed during the stuff bit.
  - Any 0 clears ones_cnt.
  - A stuff bit due after the final data bit is sent before EOP.
- End of byte: if the byte was tx_last, the FSM moves to EOP_SE0 at the boundary after its last bit (or after its trailing stuff bit).
- Underrun: the shift register empties, hold is empty, and tx_last has not been sent. The FSM goes straight to EOP_SE0 at that bit boundary and tx_err pulses for 1 cycle.
- EOP_SE0: SE0 for 2 bit times.
- EOP_J: J for 1 bit time. Then tx_oe=0 and tx_busy=0 in the same cycle the FSM enters IDLE, and tx_ready=1.
- Back-to-back packets: a handshake in the IDLE entry cycle is legal and starts SYNC on the next cycle.
- tx_valid with tx_ready=0 is ignored; the source must hold the byte.

Decomposition:
- Shared package usb_pkg: typedef enum tx_state_t {IDLE, SYNC, DATA, EOP_SE0, EOP_J}; constants SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2; line-state encodings J/K/SE0.
- One natural sub-module: usb_bit_stuffer. It takes a bit plus a bit-time strobe and produces the stuffed bit, a stall (do-not-consume) flag, and the NRZI level.

Test Plan:
1. Reset asserted mid-DATA -> dp=1, dm=0, tx_oe=0, tx_busy=0 asynchronously; the next packet starts with a clean SYNC.
2. One byte 0x00, tx_last=1, CLKS_PER_BIT=4 -> from T+1: SYNC KJKJKJKK, then 8 alternating bits JKJKJKJK, SE0 8 cycles, J 4 cycles, tx_oe falls at T+1+76 with the FSM in IDLE. tx_err stays 0.
3. One byte 0xFF, tx_last=1 -> after SYNC: K held 5 bit times, stuffed J, J held 3 bits (9 data bit times), then SE0 SE0 J.
4. Bytes 0xA5, 0x3C streamed with tx_valid held -> no gap between bytes on the line. tx_ready deasserts while hold is full. The decoded line (NRZI decode plus destuff) reproduces A5 3C.
5. Two bytes with tx_last never asserted and tx_valid dropped after the 2nd -> EOP starts at the bit boundary after byte 2 ends. tx_err pulses exactly 1 cycle.
6. New tx_valid in the same cycle tx_oe falls -> accepted; K appears on the next cycle; no extra idle bit is required.
